// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer and the 8-bit CPU core.
// Holds the sequencer state encoding, the idle opcode and the core's 4-bit ISA opcodes.
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam logic [3:0] OP_MVR = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STB = 4'h2;
  localparam logic [3:0] OP_RDS = 4'h3;
  localparam logic [3:0] OP_NOP = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_ADD = 4'h9;
  localparam logic [3:0] OP_SUB = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  // Opcode in the high nibble; a zero low nibble leaves the register file untouched.
  localparam logic [7:0] NOP_INST = {OP_NOP, 4'h0};

  function automatic logic [15:0] pack_word(input logic [7:0] inst, input logic [7:0] data);
    return {inst, data};
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the instruction sequencer: DEPTH x W, one write port,
// asynchronous read, contents deliberately left unreset.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write port; no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_inst_sequencer.sv
// Stores a short program of {opcode, operand} words and replays it onto the CPU core buses.
// Optional macro SEQ_HOLD_EN adds a 'hold' input that pauses replay without losing position.
module cpu_inst_sequencer #(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter logic [7:0] NOP_INST = seq_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_inst,
  input  logic [7:0]  load_data,
  input  logic [7:0]  loops,
  input  logic        start,
  input  logic        stop,
`ifdef SEQ_HOLD_EN
  input  logic        hold,
`endif
  output logic [AW:0] prog_len,
  output logic        issue_valid,
  output logic [7:0]  issue_inst,
  output logic [7:0]  issue_data,
  output logic        busy,
  output logic        done
);

  import seq_pkg::*;

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEN  = (AW+1)'(1);

  seq_state_e    r_state;
  logic [AW:0]   r_prog_len;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_pass_cnt;
  logic          r_issue_valid;
  logic [7:0]    r_issue_inst;
  logic [7:0]    r_issue_data;
  logic          r_busy;
  logic          r_done;

  logic          w_load_fire;
  logic          w_last;
  logic          w_hold;
  logic [15:0]   w_rd_word;

`ifdef SEQ_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign load_ready  = (r_state == IDLE) && (r_prog_len < FULL_LEN) && !clear;
  assign w_load_fire = load_valid && load_ready;
  assign w_last      = ({1'b0, r_pc} == (r_prog_len - ONE_LEN));

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (16)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_load_fire),
    .i_waddr (r_prog_len[AW-1:0]),
    .i_wdata (pack_word(load_inst, load_data)),
    .i_raddr (r_pc),
    .o_rdata (w_rd_word)
  );

  // Sequencer FSM with program length, replay pointer and registered issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_prog_len    <= '0;
      r_pc          <= '0;
      r_pass_cnt    <= 8'h00;
      r_issue_valid <= 1'b0;
      r_issue_inst  <= NOP_INST;
      r_issue_data  <= 8'h00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_prog_len    <= '0;
      r_pc          <= '0;
      r_pass_cnt    <= r_pass_cnt;
      r_issue_valid <= 1'b0;
      r_issue_inst  <= NOP_INST;
      r_issue_data  <= 8'h00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_issue_valid <= 1'b0;
          r_issue_inst  <= NOP_INST;
          r_issue_data  <= 8'h00;
          r_done        <= 1'b0;
          if (w_load_fire) begin
            r_prog_len <= r_prog_len + ONE_LEN;
          end else begin
            r_prog_len <= r_prog_len;
          end
          // Start looks at the length before any same-cycle load lands.
          if (start && !stop && (r_prog_len != '0)) begin
            r_state    <= RUN;
            r_pc       <= '0;
            r_pass_cnt <= loops;
            r_busy     <= 1'b1;
          end else begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            r_state       <= IDLE;
            r_issue_valid <= 1'b0;
            r_issue_inst  <= NOP_INST;
            r_issue_data  <= 8'h00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
          end else if (w_hold) begin
            r_issue_valid <= 1'b0;
            r_issue_inst  <= NOP_INST;
            r_issue_data  <= 8'h00;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end else begin
            r_issue_valid <= 1'b1;
            r_issue_inst  <= w_rd_word[15:8];
            r_issue_data  <= w_rd_word[7:0];
            if (w_last) begin
              if (r_pass_cnt != 8'h00) begin
                r_pc       <= '0;
                r_pass_cnt <= r_pass_cnt - 8'h01;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
              end else begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end
            end else begin
              r_pc   <= r_pc + {{(AW-1){1'b0}}, 1'b1};
              r_busy <= 1'b1;
              r_done <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_issue_valid <= 1'b0;
          r_issue_inst  <= NOP_INST;
          r_issue_data  <= 8'h00;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign prog_len    = r_prog_len;
  assign issue_valid = r_issue_valid;
  assign issue_inst  = r_issue_inst;
  assign issue_data  = r_issue_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/cpu_inst_sequencer.md
Name: cpu_inst_sequencer

Overview:
- Upstream feeder for the 8-bit CPU core. It stores a short program of 16-bit instruction words and replays them, one per clock, onto the core's instruction/operand buses.
- Each word is an opcode byte for ui_in plus an operand byte for uio_in.
- Replaces manual per-cycle driving of the pins. Supports repeat passes and early stop.
- When no instruction is being issued, it drives a NOP so the core's register file is never written.

Parameters:
- DEPTH, 16, number of program entries.
- AW, 4, pointer width, equal to log2(DEPTH).
- NOP_INST, 8'h40, opcode byte issued when idle (opcode 4'b0100 is a NOP in the ISA).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous; empties the program and returns to IDLE.
- load_valid  in  1  load request for one program entry.
- load_ready  out  1  high when a load is accepted.
- load_inst  in  8  opcode byte to store.
- load_data  in  8  operand byte to store.
- loops  in  8  extra passes, sampled at start; total passes = loops+1.
- start  in  1  begin replay.
- stop  in  1  abort replay.
- prog_len  out  AW+1  number of stored entries, 0..DEPTH.
- issue_valid  out  1  issue_inst/issue_data hold a real instruction.
- issue_inst  out  8  drives core ui_in.
- issue_data  out  8  drives core uio_in.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE, prog_len=0, pc=0, issue_valid=0, issue_inst=NOP_INST, issue_data=0, busy=0, done=0. Memory contents are not reset.
- All outputs are registered except load_ready. load_ready = (state==IDLE) && (prog_len<DEPTH) && !clear.
- Load: on an edge with load_valid && load_ready, mem[prog_len] <= {load_inst, load_data} and prog_len increments. A load while full or in RUN is ignored with no side effects.
- IDLE -> RUN: start && !stop && !clear && prog_len!=0. Sets pc=0 and pass_cnt=loops.
  - start with prog_len==0 is ignored.
  - start while in RUN is ignored.
- RUN, each edge:
  - issue regs <= mem[pc]; issue_valid <= 1.
  - If pc==prog_len-1 and pass_cnt!=0: pc <= 0 (wrap), pass_cnt decrements.
  - If pc==prog_len-1 and pass_cnt==0: state <= IDLE, done <= 1.
  - Otherwise pc increments.
- Latency: first issue_valid appears the cycle after start is sampled. Issues are back-to-back with no bubbles, including across the wrap.
- done is high in the same cycle as the last issue_valid and low otherwise.
- IDLE edge: issue_valid <= 0, issue_inst <= NOP_INST, issue_data <= 0, done <= 0.
- stop in RUN: the next edge goes to IDLE and issues NOP (valid 0); done is not pulsed.
- stop and start in the same IDLE cycle: stop wins.
- clear behaves as stop and also sets prog_len=0 and pc=0. clear has priority over load, start and stop.
- busy = (state==RUN), registered; it falls on the same edge as the final issue.

Optional Feature:
- Macro: SEQ_HOLD_EN.
- Defined: adds input port hold (1 bit). While hold=1 in RUN, each edge issues NOP with issue_valid=0, and pc/pass_cnt freeze. Replay resumes at the frozen pc when hold drops. stop and clear take priority over hold. hold has no effect in IDLE.
- Undefined: the port is absent and replay never pauses.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {IDLE, RUN};
  - NOP_INST constant;
  - 4-bit ISA opcode constants (MVR, LDB, STB, RDS, NOT…MUL), shared with the CPU core.
- One sub-module is natural: seq_prog_mem, a DEPTH x 16 single-write-port, asynchronous-read array with no reset.
- The FSM, pointers and output registers stay in cpu_inst_sequencer.

Test Plan:
- Load {11,05}, {12,03}, {B3,12}; start with loops=0.
  - Required: issues 11/05, 12/03, B3/12 on three consecutive cycles, starting one cycle after start.
  - done is high with B3/12; the next cycle shows 40/00 with valid 0; busy is 0.
- Same program with loops=2.
  - Required: 9 consecutive issues with the pattern repeating, pc wrapping 2->0 without a bubble.
  - done is only on the 9th issue.
- Load 16 entries, then hold load_valid for a 17th.
  - Required: load_ready=0, prog_len stays 16, entry 15 is unchanged.
- 3-entry program; assert stop during the 2nd issue cycle.
  - Required: entry 3 is never issued, done stays 0, busy is low next cycle.
- Drive rst_n low mid-RUN.
  - Required: immediately issue_valid=0, issue_inst=40, busy=0, prog_len=0.
  - After release, start produces no issue.
- With SEQ_HOLD_EN defined: hold=1 for 2 cycles after the 1st issue.
  - Required: two NOP cycles, then entry 2 resumes; total issue count is unchanged.
